// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv
//  Purpose  : Iterative radix-2 multiply/divide unit for the 8088 execution
//             stage. Handles MUL, IMUL, DIV and IDIV in byte and word forms.
//             Signed operations run on magnitudes; signs are restored in FIX.
//  Ports    : CLK, RESET_n (async, active low)
//             Start, Operation[1:0] (00 MUL, 01 IMUL, 10 DIV, 11 IDIV),
//             byteWord (1 = word), OpLo (AX), OpHi (DX), Src (r/m operand)
//             ResLo (new AX), ResHi (new DX), Busy, Done, DivError,
//             F_Carry, F_Overflow
//  Revision : 1.0  initial release
// ============================================================================
module muldiv (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        Start,
    input  logic [1:0]  Operation,
    input  logic        byteWord,
    input  logic [15:0] OpLo,
    input  logic [15:0] OpHi,
    input  logic [15:0] Src,
    output logic [15:0] ResLo,
    output logic [15:0] ResHi,
    output logic        Busy,
    output logic        Done,
    output logic        DivError,
    output logic        F_Carry,
    output logic        F_Overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state, state_nx;

    // Captured request
    logic [1:0]  op;
    logic        bw;
    logic [15:0] lo_q, hi_q, src_q;

    // Datapath
    logic [15:0] a_mag;     // multiplicand magnitude / dividend low half
    logic [15:0] b_mag;     // multiplier / divisor magnitude
    logic [31:0] acc;       // product accumulator; [15:0] = partial remainder
    logic [15:0] quot;
    logic [3:0]  cnt;
    logic        neg_q;     // negate product / quotient in FIX
    logic        neg_r;     // negate remainder in FIX

    logic        is_signed, is_div, accept;
    assign is_signed = op[0];
    assign is_div    = op[1];
    assign accept    = Start && (state == S_IDLE || state == S_DONE);

    // ---------------- PREP: magnitudes and early divide check ----------------
    logic        src_neg, mcand_neg, dvd_neg, early_err;
    logic [15:0] src_mag, mcand_mag, dvd_hi_mag, dvd_lo_mag;
    logic [31:0] dvd_raw, dvd_mag;

    assign src_neg   = is_signed & (bw ? src_q[15] : src_q[7]);
    assign mcand_neg = is_signed & (bw ? lo_q[15]  : lo_q[7]);
    assign dvd_neg   = is_signed & (bw ? hi_q[15]  : lo_q[15]);

    assign src_mag   = bw ? (src_neg ? 16'd0 - src_q : src_q)
                          : {8'h00, (src_neg ? 8'd0 - src_q[7:0] : src_q[7:0])};
    assign mcand_mag = bw ? (mcand_neg ? 16'd0 - lo_q : lo_q)
                          : {8'h00, (mcand_neg ? 8'd0 - lo_q[7:0] : lo_q[7:0])};

    // Byte dividend is all of AX; only the low 16 bits of its magnitude matter.
    assign dvd_raw    = bw ? {hi_q, lo_q} : {16'h0000, lo_q};
    assign dvd_mag    = dvd_neg ? 32'd0 - dvd_raw : dvd_raw;
    assign dvd_hi_mag = bw ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
    assign dvd_lo_mag = bw ? dvd_mag[15:0]  : {8'h00, dvd_mag[7:0]};

    // A high half at or above the divisor means the quotient needs > N bits.
    assign early_err  = (src_mag == 16'd0) || (dvd_hi_mag >= src_mag);

    // ---------------- ITER: one bit per cycle, MSB first ----------------
    logic [16:0] div_trial, div_diff;
    logic        div_fits;
    logic [31:0] mul_add;

    assign div_trial = {acc[15:0], a_mag[cnt]};
    assign div_fits  = div_trial >= {1'b0, b_mag};
    assign div_diff  = div_trial - {1'b0, b_mag};
    assign mul_add   = b_mag[cnt] ? {16'h0000, a_mag} : 32'h0000_0000;

    // ---------------- FIX: sign restore, flags, range check ----------------
    logic [31:0] prod_s;
    logic [15:0] quot_s, rem_s;
    logic        mul_flag, quot_ovf;

    assign prod_s = neg_q ? 32'd0 - acc : acc;
    assign quot_s = neg_q ? 16'd0 - quot : quot;
    assign rem_s  = neg_r ? 16'd0 - acc[15:0] : acc[15:0];

    always_comb begin
        mul_flag = 1'b0;
        if (bw)
            mul_flag = is_signed ? (prod_s[31:16] != {16{prod_s[15]}})
                                 : (prod_s[31:16] != 16'h0000);
        else
            mul_flag = is_signed ? (prod_s[15:8] != {8{prod_s[7]}})
                                 : (prod_s[15:8] != 8'h00);
    end

    // Magnitude must stay below 2^(N-1); this also rejects -2^(N-1).
    assign quot_ovf = is_signed & (bw ? quot[15] : quot[7]);

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            S_IDLE: if (Start) state_nx = S_PREP;
            S_PREP: begin
                Busy     = 1'b1;
                state_nx = (is_div && early_err) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                Busy = 1'b1;
                if (cnt == 4'd0) state_nx = S_FIX;
            end
            S_FIX: begin
                Busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                Done     = 1'b1;
                state_nx = Start ? S_PREP : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- Datapath and result registers ----------------
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            op <= 2'b00;  bw <= 1'b0;
            lo_q <= 16'h0; hi_q <= 16'h0; src_q <= 16'h0;
            a_mag <= 16'h0; b_mag <= 16'h0; acc <= 32'h0; quot <= 16'h0;
            cnt <= 4'd0; neg_q <= 1'b0; neg_r <= 1'b0;
            ResLo <= 16'h0; ResHi <= 16'h0;
            DivError <= 1'b0; F_Carry <= 1'b0; F_Overflow <= 1'b0;
        end else begin
            if (accept) begin
                op <= Operation; bw <= byteWord;
                lo_q <= OpLo; hi_q <= OpHi; src_q <= Src;
            end
            case (state)
                S_PREP: begin
                    b_mag <= src_mag;
                    quot  <= 16'h0;
                    cnt   <= bw ? 4'd15 : 4'd7;
                    if (is_div) begin
                        a_mag <= dvd_lo_mag;
                        acc   <= {16'h0000, dvd_hi_mag};
                        neg_q <= dvd_neg ^ src_neg;
                        neg_r <= dvd_neg;
                        if (early_err) begin
                            ResLo <= lo_q; ResHi <= hi_q;
                            DivError <= 1'b1; F_Carry <= 1'b0; F_Overflow <= 1'b0;
                        end
                    end else begin
                        a_mag <= mcand_mag;
                        acc   <= 32'h0;
                        neg_q <= mcand_neg ^ src_neg;
                        neg_r <= 1'b0;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - 4'd1;
                    if (is_div) begin
                        acc[15:0] <= div_fits ? div_diff[15:0] : div_trial[15:0];
                        quot      <= {quot[14:0], div_fits};
                    end else begin
                        acc <= {acc[30:0], 1'b0} + mul_add;
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        ResLo      <= prod_s[15:0];
                        ResHi      <= bw ? prod_s[31:16] : hi_q;
                        DivError   <= 1'b0;
                        F_Carry    <= mul_flag;
                        F_Overflow <= mul_flag;
                    end else if (quot_ovf) begin
                        ResLo <= lo_q; ResHi <= hi_q;
                        DivError <= 1'b1; F_Carry <= 1'b0; F_Overflow <= 1'b0;
                    end else begin
                        ResLo      <= bw ? quot_s : {rem_s[7:0], quot_s[7:0]};
                        ResHi      <= bw ? rem_s : hi_q;
                        DivError   <= 1'b0;
                        F_Carry    <= 1'b0;
                        F_Overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv
//  Purpose  : Self-checking bench for muldiv. Expected results come from an
//             arithmetic reference model (signed/unsigned 64-bit math).
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Operation = 2'b00;
    logic        byteWord = 1'b0;
    logic [15:0] OpLo = 16'h0, OpHi = 16'h0, Src = 16'h0;
    logic [15:0] ResLo, ResHi;
    logic        Busy, Done, DivError, F_Carry, F_Overflow;

    muldiv dut (
        .CLK(CLK), .RESET_n(RESET_n), .Start(Start), .Operation(Operation),
        .byteWord(byteWord), .OpLo(OpLo), .OpHi(OpHi), .Src(Src),
        .ResLo(ResLo), .ResHi(ResHi), .Busy(Busy), .Done(Done),
        .DivError(DivError), .F_Carry(F_Carry), .F_Overflow(F_Overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [15:0] e_lo, e_hi;
    logic        e_fl, e_err;
    int          e_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural values.
    function automatic void model(input logic [1:0] op, input logic bw,
                                  input logic [15:0] lo, input logic [15:0] hi,
                                  input logic [15:0] src,
                                  output logic [15:0] rlo, output logic [15:0] rhi,
                                  output logic fl, output logic err, output int lat);
        int     n   = bw ? 16 : 8;
        longint lim = longint'(1) << n;
        bit     sgn = op[0];
        longint a, b, p, dd, q, r, ad, ab;
        b = bw ? longint'(src) : longint'(src[7:0]);
        if (sgn && b >= lim / 2) b -= lim;
        rlo = lo; rhi = hi; fl = 1'b0; err = 1'b0; lat = n + 3;
        if (!op[1]) begin
            a = bw ? longint'(lo) : longint'(lo[7:0]);
            if (sgn && a >= lim / 2) a -= lim;
            p = a * b;
            if (bw) begin rlo = p[15:0]; rhi = p[31:16]; end
            else      rlo = p[15:0];
            fl = sgn ? (p < -(lim / 2) || p >= lim / 2) : (p >= lim);
        end else begin
            dd = bw ? longint'({hi, lo}) : longint'(lo);
            if (sgn && dd >= lim * lim / 2) dd -= lim * lim;
            ad = (dd < 0) ? -dd : dd;
            ab = (b < 0) ? -b : b;
            if (b == 0 || ad >= ab * lim) begin
                err = 1'b1; lat = 2;
            end else begin
                q = dd / b; r = dd % b;
                if (sgn ? (q > lim / 2 - 1 || q < -(lim / 2 - 1)) : (q > lim - 1))
                    err = 1'b1;
                else if (bw) begin rlo = q[15:0]; rhi = r[15:0]; end
                else rlo = {r[7:0], q[7:0]};
            end
        end
    endfunction

    // Drive a request; returns one sample (#1) after the accepting edge (cycle 1).
    task automatic issue(input logic [1:0] op, input logic bw, input logic [15:0] lo,
                         input logic [15:0] hi, input logic [15:0] src);
        Operation = op; byteWord = bw; OpLo = lo; OpHi = hi; Src = src;
        model(op, bw, lo, hi, src, e_lo, e_hi, e_fl, e_err, e_lat);
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    // Wait (bounded) for Done, checking latency, Busy and the results.
    task automatic finish(input string tag, input bit poke);
        int cyc = 1;
        bit busy_ok = 1'b1;
        while (Done !== 1'b1 && cyc < 40) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (poke && cyc == 3) begin
                Start = 1'b1; OpLo = 16'($urandom); Src = 16'($urandom);
                Operation = 2'($urandom);
            end else
                Start = 1'b0;
            @(posedge CLK); #1;
            cyc++;
        end
        Start = 1'b0;
        chk({tag, "_lat"},   cyc,        e_lat);
        chk({tag, "_busy"},  busy_ok,    1);
        chk({tag, "_bdone"}, Busy,       0);
        chk({tag, "_lo"},    ResLo,      e_lo);
        chk({tag, "_hi"},    ResHi,      e_hi);
        chk({tag, "_cf"},    F_Carry,    e_fl);
        chk({tag, "_of"},    F_Overflow, e_fl);
        chk({tag, "_derr"},  DivError,   e_err);
    endtask

    initial begin
        logic [1:0]  rop;
        logic        rbw;
        logic [15:0] rlo, rhi, rsrc;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_lo", ResLo, 0);
        chk("rst_hi", ResHi, 0);
        RESET_n = 1'b1;
        @(posedge CLK); #1;

        // Directed cases
        issue(2'b00, 1'b0, 16'h00FF, 16'h1234, 16'h00FF);
        finish("mul_b", 1'b0);
        chk("mul_b_val", ResLo, 16'hFE01);
        @(posedge CLK); #1;
        chk("done_pulse", Done, 0);
        chk("hold_lo", ResLo, 16'hFE01);

        issue(2'b01, 1'b1, 16'hFFFF, 16'h0000, 16'h0002);
        finish("imul_w1", 1'b0);
        chk("imul_w1_val", {ResHi, ResLo}, 32'hFFFF_FFFE);
        issue(2'b01, 1'b1, 16'h4000, 16'h5555, 16'h0002);     // back-to-back
        finish("imul_w2", 1'b0);
        chk("imul_w2_val", {ResHi, ResLo, 7'd0, F_Carry}, {32'h0000_8000, 8'd1});

        issue(2'b10, 1'b1, 16'h0000, 16'h0001, 16'h0003);
        finish("div_w", 1'b1);                                // Start pokes while Busy
        chk("div_w_val", {ResHi, ResLo}, 32'h0001_5555);

        issue(2'b11, 1'b0, 16'hFFF9, 16'hABCD, 16'h0002);
        finish("idiv_b", 1'b0);
        chk("idiv_b_val", ResLo, 16'hFFFD);

        issue(2'b10, 1'b1, 16'h1357, 16'h2468, 16'h0000);
        finish("div0", 1'b0);
        chk("div0_val", {ResHi, ResLo, 7'd0, DivError}, {32'h2468_1357, 8'd1});

        issue(2'b10, 1'b0, 16'h0200, 16'h0000, 16'h0002);
        finish("divb_ovf", 1'b0);
        issue(2'b11, 1'b0, 16'h0080, 16'h0000, 16'h0001);
        finish("idivb_m128", 1'b0);
        chk("idivb_m128_lat", e_lat, 11);
        issue(2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'hFFFF);   // -32768 / -1
        finish("idivw_ovf", 1'b0);
        issue(2'b11, 1'b1, 16'h8001, 16'hFFFF, 16'hFFFF);   // -32767 / -1 fits
        finish("idivw_edge", 1'b0);

        // Randomized, every op started in the previous op's Done cycle
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom); rbw = 1'($urandom);
            rlo = 16'($urandom); rhi = 16'($urandom); rsrc = 16'($urandom);
            if (i % 2 == 0) begin
                rhi = 16'($urandom_range(0, 2));
                rlo[15:8] = 8'($urandom_range(0, 2));
            end
            issue(rop, rbw, rlo, rhi, rsrc);
            finish($sformatf("rnd%0d", i), (i % 5) == 0);
        end
        @(posedge CLK); #1;

        // Reset in the middle of a word divide
        issue(2'b10, 1'b1, 16'h1111, 16'h0001, 16'h0007);
        repeat (4) @(posedge CLK);
        #1;
        RESET_n = 1'b0;
        #1;
        chk("mrst_busy", Busy, 0);
        chk("mrst_done", Done, 0);
        chk("mrst_flags", {DivError, F_Carry, F_Overflow}, 0);
        chk("mrst_res", {ResHi, ResLo}, 0);
        @(posedge CLK); #1;
        RESET_n = 1'b1;
        @(posedge CLK); #1;
        issue(2'b00, 1'b0, 16'h0003, 16'h0000, 16'h0004);
        finish("post_rst", 1'b0);
        chk("post_rst_val", ResLo, 16'h000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
